// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO command arbiter: FSM states, opcodes and
// the bit layout of a command word.
package gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_e;

  typedef enum logic [2:0] {
    OP_WRITE_BIT     = 3'd0,
    OP_WRITE_BYTE    = 3'd1,
    OP_SET_BIT       = 3'd2,
    OP_CLEAR_BIT     = 3'd3,
    OP_TOGGLE_BIT    = 3'd4,
    OP_READ_PIN_BIT  = 3'd5,
    OP_READ_PIN_BYTE = 3'd6,
    OP_PULSE_BIT     = 3'd7
  } gpio_op_e;

  localparam int CMD_ADDR_MSB = 15;
  localparam int CMD_ADDR_LSB = 13;
  localparam int CMD_OP_MSB   = 12;
  localparam int CMD_OP_LSB   = 10;
  localparam int CMD_VAL_MSB  = 9;
  localparam int CMD_VAL_LSB  = 0;

  function automatic gpio_op_e cmd_opcode(input logic [15:0] cmd);
    return gpio_op_e'(cmd[CMD_OP_MSB:CMD_OP_LSB]);
  endfunction

endpackage

// File: rtl/gpio_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request at or after
// the pointer, wrapping around, as one-hot grant plus binary index.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Round-robin arbiter sharing one GPIO controller command port among
// NUM_REQ requesters, with a single registered response path back.
module gpio_arbiter
  import gpio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic                      clk_en,
  input  logic [NUM_REQ-1:0]        Req_REQ,
  output logic [NUM_REQ-1:0]        Req_ACK,
  input  logic [NUM_REQ-1:0]        Req_ResponseRequested,
  input  logic [NUM_REQ*REG_W-1:0]  Req_DestReg,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic                      IO_REQ,
  output logic                      IO_CommandEn,
  input  logic                      IO_ACK,
  output logic                      IO_ResponseRequested,
  output logic [REG_W-1:0]          IO_DestRegIn,
  output logic [DATA_W-1:0]         IO_DataIn,
  input  logic                      IO_RegResponseFlag,
  input  logic [REG_W-1:0]          IO_DestRegOut,
  input  logic [DATA_W-1:0]         IO_DataOut,
  output logic [NUM_REQ-1:0]        Rsp_Valid,
  input  logic [NUM_REQ-1:0]        Rsp_Ready,
  output logic [REG_W-1:0]          Rsp_DestReg,
  output logic [DATA_W-1:0]         Rsp_Data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [DATA_W-1:0]  r_cmd_data;
  logic [REG_W-1:0]   r_cmd_dest;
  logic               r_cmd_rsp;
  logic               r_io_req;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [REG_W-1:0]   r_rsp_dest;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_accept;
  logic [DATA_W-1:0]  w_sel_data;
  logic [REG_W-1:0]   w_sel_dest;
  logic               w_sel_rsp;
  logic [NUM_REQ-1:0] w_owner_onehot;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (Req_REQ),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Winner's command fields, muxed with constant slice bases.
  always_comb begin
    w_sel_data = '0;
    w_sel_dest = '0;
    w_sel_rsp  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_data = Req_Data[i*DATA_W +: DATA_W];
        w_sel_dest = Req_DestReg[i*REG_W +: REG_W];
        w_sel_rsp  = Req_ResponseRequested[i];
      end
    end
  end

  assign w_next_ptr     = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_owner_onehot = NUM_REQ'(1) << r_owner;

  // The accept pulse is the only combinational output: it must coincide with
  // the cycle in which the winner's fields are latched.
  assign w_accept = (r_state == ST_IDLE) && clk_en && !sync_rst && w_any;
  assign Req_ACK  = w_accept ? w_grant : '0;

  // NOTE: non-blocking assignments only; the command and response latches
  // are reset too, so a dropped command leaves nothing stale on the outputs.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cmd_data  <= '0;
      r_cmd_dest  <= '0;
      r_cmd_rsp   <= 1'b0;
      r_io_req    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_dest  <= '0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_cmd_data <= w_sel_data;
            r_cmd_dest <= w_sel_dest;
            r_cmd_rsp  <= w_sel_rsp;
            r_owner    <= w_idx;
            r_ptr      <= w_next_ptr;
            r_io_req   <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (IO_ACK) begin
            r_rsp_data <= IO_DataOut;
            r_rsp_dest <= IO_DestRegOut;
            r_io_req   <= 1'b0;
            if (IO_RegResponseFlag) begin
              r_rsp_valid <= w_owner_onehot;
              r_state     <= ST_RESPOND;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RESPOND: begin
          // Only the owner's ready can retire the response.
          if (Rsp_Ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_io_req    <= 1'b0;
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign IO_REQ               = r_io_req;
  assign IO_CommandEn         = r_io_req;
  assign IO_ResponseRequested = r_cmd_rsp;
  assign IO_DestRegIn         = r_cmd_dest;
  assign IO_DataIn            = r_cmd_data;
  assign Rsp_Valid            = r_rsp_valid;
  assign Rsp_DestReg          = r_rsp_dest;
  assign Rsp_Data             = r_rsp_data;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: reset, single write, rotation, response
// hold, IO stall, clock-enable freeze and reset in RESPOND.
module tb_gpio_arbiter;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        clk_en;
  logic [3:0]  Req_REQ;
  logic [3:0]  Req_ACK;
  logic [3:0]  Req_ResponseRequested;
  logic [15:0] Req_DestReg;
  logic [63:0] Req_Data;
  logic        IO_REQ;
  logic        IO_CommandEn;
  logic        IO_ACK;
  logic        IO_ResponseRequested;
  logic [3:0]  IO_DestRegIn;
  logic [15:0] IO_DataIn;
  logic        IO_RegResponseFlag;
  logic [3:0]  IO_DestRegOut;
  logic [15:0] IO_DataOut;
  logic [3:0]  Rsp_Valid;
  logic [3:0]  Rsp_Ready;
  logic [3:0]  Rsp_DestReg;
  logic [15:0] Rsp_Data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_arbiter #(.NUM_REQ(4), .DATA_W(16), .REG_W(4)) dut (
    .clk                   (clk),
    .sync_rst              (sync_rst),
    .clk_en                (clk_en),
    .Req_REQ               (Req_REQ),
    .Req_ACK               (Req_ACK),
    .Req_ResponseRequested (Req_ResponseRequested),
    .Req_DestReg           (Req_DestReg),
    .Req_Data              (Req_Data),
    .IO_REQ                (IO_REQ),
    .IO_CommandEn          (IO_CommandEn),
    .IO_ACK                (IO_ACK),
    .IO_ResponseRequested  (IO_ResponseRequested),
    .IO_DestRegIn          (IO_DestRegIn),
    .IO_DataIn             (IO_DataIn),
    .IO_RegResponseFlag    (IO_RegResponseFlag),
    .IO_DestRegOut         (IO_DestRegOut),
    .IO_DataOut            (IO_DataOut),
    .Rsp_Valid             (Rsp_Valid),
    .Rsp_Ready             (Rsp_Ready),
    .Rsp_DestReg           (Rsp_DestReg),
    .Rsp_Data              (Rsp_Data)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1; clk_en = 1'b1; Req_REQ = 4'b1111;
    Req_ResponseRequested = '0; Req_DestReg = '0; Req_Data = '0;
    IO_ACK = 1'b0; IO_RegResponseFlag = 1'b0; IO_DestRegOut = '0;
    IO_DataOut = '0; Rsp_Ready = '0;
    next_cycle(); next_cycle();
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", Req_ACK); end
    n_tests++; if ({IO_REQ, IO_CommandEn} !== 2'b00) begin n_fail++; $display("FAIL rst_ioreq: got %b want 00", {IO_REQ, IO_CommandEn}); end
    n_tests++; if (Rsp_Valid !== 4'b0000) begin n_fail++; $display("FAIL rst_rspvalid: got %b want 0000", Rsp_Valid); end
    next_cycle();
    sync_rst = 1'b0; Req_REQ = 4'b0000;
    @(negedge clk);
    n_tests++; if ({IO_DataIn, IO_DestRegIn, IO_ResponseRequested} !== 21'd0) begin n_fail++; $display("FAIL rst_iofields: got %h/%h/%b want 0", IO_DataIn, IO_DestRegIn, IO_ResponseRequested); end
    n_tests++; if ({Rsp_Data, Rsp_DestReg} !== 20'd0) begin n_fail++; $display("FAIL rst_rspfields: got %h/%h want 0", Rsp_Data, Rsp_DestReg); end
    next_cycle();
  endtask

  // Requester 2 sends WriteByte addr0 with no response; IO_ACK held high.
  task automatic test_single_write();
    Req_Data[2*16 +: 16] = 16'h0401;
    Req_DestReg[2*4 +: 4] = 4'h3;
    Req_ResponseRequested[2] = 1'b0;
    IO_ACK = 1'b1; IO_RegResponseFlag = 1'b0;
    Req_REQ = 4'b0100;
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", Req_ACK); end
    n_tests++; if (IO_REQ !== 1'b0) begin n_fail++; $display("FAIL single_ioreq_early: got %b want 0", IO_REQ); end
    next_cycle();
    Req_REQ = 4'b0000;
    @(negedge clk);
    n_tests++; if ({IO_REQ, IO_CommandEn} !== 2'b11) begin n_fail++; $display("FAIL single_ioreq: got %b want 11", {IO_REQ, IO_CommandEn}); end
    n_tests++; if (IO_DataIn !== 16'h0401) begin n_fail++; $display("FAIL single_data: got %h want 0401", IO_DataIn); end
    n_tests++; if ({IO_DestRegIn, IO_ResponseRequested} !== 5'b0011_0) begin n_fail++; $display("FAIL single_fields: got %h/%b want 3/0", IO_DestRegIn, IO_ResponseRequested); end
    n_tests++; if (Req_ACK !== 4'b0000) begin n_fail++; $display("FAIL single_ack_gone: got %b want 0000", Req_ACK); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (IO_REQ !== 1'b0) begin n_fail++; $display("FAIL single_ioreq_one_cycle: got %b want 0", IO_REQ); end
    n_tests++; if (Rsp_Valid !== 4'b0000) begin n_fail++; $display("FAIL single_no_rsp: got %b want 0000", Rsp_Valid); end
    next_cycle();
  endtask

  // Fresh reset puts ptr at 0; all four held gives 0,1,2,3,0 with wrap.
  task automatic test_round_robin();
    logic [3:0] exp_ack;
    sync_rst = 1'b1;
    next_cycle();
    sync_rst = 1'b0;
    for (int i = 0; i < 4; i++) Req_Data[i*16 +: 16] = 16'h0400 + 16'(i);
    Req_REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << (k % 4);
      @(negedge clk);
      n_tests++; if (Req_ACK !== exp_ack) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, Req_ACK, exp_ack); end
      next_cycle();
      @(negedge clk);
      n_tests++; if (IO_REQ !== 1'b1 || IO_DataIn !== 16'h0400 + 16'(k % 4) || Req_ACK !== 4'b0000) begin
        n_fail++; $display("FAIL rr_issue%0d: got req=%b data=%h ack=%b want 1/%h/0000", k, IO_REQ, IO_DataIn, Req_ACK, 16'h0400 + 16'(k % 4));
      end
      next_cycle();
    end
  endtask

  // Requester 1 ReadPinByte with response; owner holds Rsp_Ready low 3 cycles
  // while the other requesters' ready bits are high and must be ignored.
  task automatic test_response();
    Req_Data[1*16 +: 16] = 16'h1800;
    Req_DestReg[1*4 +: 4] = 4'h5;
    Req_ResponseRequested[1] = 1'b1;
    IO_ACK = 1'b1; IO_RegResponseFlag = 1'b1;
    IO_DataOut = 16'h00A5; IO_DestRegOut = 4'h5;
    Req_REQ = 4'b0010;
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b0010) begin n_fail++; $display("FAIL rsp_ack: got %b want 0010", Req_ACK); end
    next_cycle();
    Req_REQ = 4'b0000;
    @(negedge clk);
    n_tests++; if (IO_DataIn !== 16'h1800 || IO_ResponseRequested !== 1'b1 || IO_DestRegIn !== 4'h5) begin
      n_fail++; $display("FAIL rsp_issue: got %h/%b/%h want 1800/1/5", IO_DataIn, IO_ResponseRequested, IO_DestRegIn);
    end
    next_cycle();
    IO_ACK = 1'b0; IO_RegResponseFlag = 1'b0; IO_DataOut = 16'hFFFF; IO_DestRegOut = 4'hF;
    Rsp_Ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (Rsp_Valid !== 4'b0010 || Rsp_Data !== 16'h00A5 || Rsp_DestReg !== 4'h5 || IO_REQ !== 1'b0) begin
        n_fail++; $display("FAIL rsp_hold%0d: got v=%b d=%h r=%h io=%b want 0010/00a5/5/0", k, Rsp_Valid, Rsp_Data, Rsp_DestReg, IO_REQ);
      end
      next_cycle();
    end
    Rsp_Ready = 4'b0010;
    @(negedge clk);
    n_tests++; if (Rsp_Valid !== 4'b0010) begin n_fail++; $display("FAIL rsp_ready_cycle: got %b want 0010", Rsp_Valid); end
    next_cycle();
    Rsp_Ready = 4'b0000;
    @(negedge clk);
    n_tests++; if (Rsp_Valid !== 4'b0000) begin n_fail++; $display("FAIL rsp_clear: got %b want 0000", Rsp_Valid); end
    next_cycle();
  endtask

  // ptr=2: requester 3 wins over 1; IO_ACK low 4 cycles; requester 1 then
  // withdraws, so no command follows.
  task automatic test_io_stall();
    Req_Data[3*16 +: 16] = 16'h2C07;
    Req_ResponseRequested[3] = 1'b0;
    Req_REQ = 4'b1010;
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b1000) begin n_fail++; $display("FAIL stall_ack: got %b want 1000", Req_ACK); end
    next_cycle();
    Req_REQ = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++; if (IO_REQ !== 1'b1 || IO_DataIn !== 16'h2C07 || Req_ACK !== 4'b0000) begin
        n_fail++; $display("FAIL stall_hold%0d: got req=%b data=%h ack=%b want 1/2c07/0000", k, IO_REQ, IO_DataIn, Req_ACK);
      end
      next_cycle();
      if (k == 2) Req_REQ = 4'b0000;
    end
    IO_ACK = 1'b1;
    @(negedge clk);
    n_tests++; if (IO_REQ !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", IO_REQ); end
    next_cycle();
    IO_ACK = 1'b0;
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b0000 || IO_REQ !== 1'b0) begin n_fail++; $display("FAIL drop_no_ack: got ack=%b req=%b want 0000/0", Req_ACK, IO_REQ); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (IO_REQ !== 1'b0) begin n_fail++; $display("FAIL drop_no_cmd: got %b want 0", IO_REQ); end
    next_cycle();
  endtask

  // ptr=0 here. Freeze two cycles in each state, then reset from RESPOND
  // with clk_en low; afterwards ptr must be 0 again (requests 0 and 3).
  task automatic test_clk_en_and_reset();
    Req_Data[0*16 +: 16] = 16'h0C33;
    Req_DestReg[0*4 +: 4] = 4'hA;
    Req_ResponseRequested[0] = 1'b1;
    Req_REQ = 4'b0101;
    clk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (Req_ACK !== 4'b0000 || IO_REQ !== 1'b0) begin n_fail++; $display("FAIL ce_idle%0d: got ack=%b req=%b want 0000/0", k, Req_ACK, IO_REQ); end
      next_cycle();
    end
    clk_en = 1'b1;
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b0001) begin n_fail++; $display("FAIL ce_idle_grant: got %b want 0001", Req_ACK); end
    next_cycle();
    Req_REQ = 4'b0100;
    IO_ACK = 1'b1; IO_RegResponseFlag = 1'b1; IO_DataOut = 16'h1234; IO_DestRegOut = 4'h9;
    clk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (IO_REQ !== 1'b1 || IO_DataIn !== 16'h0C33 || Rsp_Valid !== 4'b0000 || Req_ACK !== 4'b0000) begin
        n_fail++; $display("FAIL ce_issue%0d: got req=%b data=%h v=%b ack=%b want 1/0c33/0000/0000", k, IO_REQ, IO_DataIn, Rsp_Valid, Req_ACK);
      end
      next_cycle();
    end
    clk_en = 1'b1;
    @(negedge clk);
    n_tests++; if (IO_REQ !== 1'b1) begin n_fail++; $display("FAIL ce_issue_resume: got %b want 1", IO_REQ); end
    next_cycle();
    IO_ACK = 1'b0; IO_RegResponseFlag = 1'b0;
    Rsp_Ready = 4'b0001;
    clk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (Rsp_Valid !== 4'b0001 || Rsp_Data !== 16'h1234 || Rsp_DestReg !== 4'h9 || Req_ACK !== 4'b0000) begin
        n_fail++; $display("FAIL ce_respond%0d: got v=%b d=%h r=%h ack=%b want 0001/1234/9/0000", k, Rsp_Valid, Rsp_Data, Rsp_DestReg, Req_ACK);
      end
      next_cycle();
    end
    sync_rst = 1'b1;
    next_cycle();
    sync_rst = 1'b0;
    Rsp_Ready = 4'b0000;
    @(negedge clk);
    n_tests++; if (Rsp_Valid !== 4'b0000 || IO_REQ !== 1'b0 || IO_CommandEn !== 1'b0 || Req_ACK !== 4'b0000) begin
      n_fail++; $display("FAIL rst_respond_ctl: got v=%b req=%b en=%b ack=%b want all 0", Rsp_Valid, IO_REQ, IO_CommandEn, Req_ACK);
    end
    n_tests++; if ({Rsp_Data, Rsp_DestReg, IO_DataIn, IO_DestRegIn, IO_ResponseRequested} !== 41'd0) begin
      n_fail++; $display("FAIL rst_respond_data: got %h/%h/%h/%h/%b want 0", Rsp_Data, Rsp_DestReg, IO_DataIn, IO_DestRegIn, IO_ResponseRequested);
    end
    next_cycle();
    clk_en = 1'b1;
    Req_REQ = 4'b1001;
    @(negedge clk);
    n_tests++; if (Req_ACK !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_zero: got %b want 0001", Req_ACK); end
    next_cycle();
    Req_REQ = 4'b0000;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_response();
    test_io_stall();
    test_clk_en_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_arbiter.md
GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the GPIO controller command port (2..8).
REQ-002 Parameter DATA_W, default 16: command/response data width.
REQ-003 Parameter REG_W, default 4: destination-register tag width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 sync_rst  in  1  reset, synchronous, active-high.
REQ-006 clk_en  in  1  global clock enable; state advances only when high.
REQ-007 Req_REQ  in  NUM_REQ  per-requester command request, held until acked.
REQ-008 Req_ACK  out  NUM_REQ  one-hot one-cycle pulse: command accepted.
REQ-009 Req_ResponseRequested  in  NUM_REQ  per-requester response wanted.
REQ-010 Req_DestReg  in  NUM_REQ*REG_W  per-requester tag, requester i at [i*REG_W +: REG_W].
REQ-011 Req_Data  in  NUM_REQ*DATA_W  per-requester command word ([15:13] addr, [12:10] opcode, [9:0] value/length).
REQ-012 IO_REQ, IO_CommandEn  out  1 each  command strobe to GPIO controller.
REQ-013 IO_ACK  in  1  controller accept.
REQ-014 IO_ResponseRequested  out  1;  IO_DestRegIn  out  REG_W;  IO_DataIn  out  DATA_W: latched command fields.
REQ-015 IO_RegResponseFlag  in  1;  IO_DestRegOut  in  REG_W;  IO_DataOut  in  DATA_W: controller response (same cycle as IO_ACK).
REQ-016 Rsp_Valid  out  NUM_REQ  one-hot response valid;  Rsp_Ready  in  NUM_REQ  per-requester accept.
REQ-017 Rsp_DestReg  out  REG_W;  Rsp_Data  out  DATA_W: registered response, shared by all requesters.

Function
REQ-018 FSM states IDLE, ISSUE, RESPOND; all transitions gated by clk_en (clk_en low freezes state, pointer, registers; Req_ACK forced 0).
REQ-019 IDLE, clk_en=1, any Req_REQ: round-robin winner chosen starting at pointer ptr; winner's Data/DestReg/ResponseRequested and index latched; Req_ACK[winner]=1 that cycle (combinational); next state ISSUE; ptr <= (winner+1) mod NUM_REQ.
REQ-020 IDLE with no request: stay IDLE, ptr unchanged.
REQ-021 ISSUE: IO_REQ=IO_CommandEn=1, IO fields from latch; on IO_ACK&&clk_en capture IO_DataOut/IO_DestRegOut into response register; next RESPOND if IO_RegResponseFlag, else IDLE.
REQ-022 ISSUE without IO_ACK: hold command stable, remain ISSUE.
REQ-023 RESPOND: Rsp_Valid[owner]=1 only, Rsp_Data/Rsp_DestReg stable; on Rsp_Ready[owner]&&clk_en next IDLE; Rsp_Ready of other requesters ignored.
REQ-024 Latency: request-to-IO_REQ 1 cycle; IO_ACK-to-Rsp_Valid 1 cycle; minimum back-to-back command spacing 2 cycles (no response) or 3 (with response).
REQ-025 IO_REQ, IO_CommandEn 0 outside ISSUE; Rsp_Valid 0 outside RESPOND.
REQ-026 Requester dropping Req_REQ before ACK is not an error; no command issued for it.
REQ-027 Pointer wrap: ptr=NUM_REQ-1 grant -> ptr=0.

Reset
REQ-028 sync_rst (priority over clk_en) -> state IDLE, ptr 0, latches and response register 0, all outputs 0, including mid-ISSUE or mid-RESPOND; in-flight command dropped, no Rsp_Valid.

Structure
REQ-029 Shared package gpio_pkg holds FSM state enum, opcode constants (WriteBit=0 .. PulseBit=7), and field positions of the command word.
REQ-030 One sub-module rr_picker: combinational round-robin one-hot selector (inputs request vector, ptr; outputs one-hot grant, index, any).

Verification
REQ-031 Single requester 2, Data=0x0401 (addr0 WriteByte), ResponseRequested=0, IO_ACK held 1 -> Req_ACK[2] pulse, IO_REQ one cycle with IO_DataIn=0x0401, return IDLE, no Rsp_Valid.
REQ-032 All four Req_REQ held continuously from ptr=0 -> grants in order 0,1,2,3,0, each exactly once per rotation.
REQ-033 Requester 1 ReadPinByte (0x1800), ResponseRequested=1, DestReg=0x5, controller returns IO_DataOut=0x00A5, RegResponseFlag=1; Rsp_Ready[1] low 3 cycles -> Rsp_Valid[1] held, Rsp_Data=0x00A5, Rsp_DestReg=0x5; clears cycle after Rsp_Ready[1]=1.
REQ-034 IO_ACK low 4 cycles during ISSUE -> IO_DataIn stable, no new Req_ACK despite pending requests.
REQ-035 clk_en low 2 cycles in each state -> no state/pointer change, Req_ACK 0; sync_rst asserted in RESPOND -> next cycle IDLE, all outputs 0, ptr 0.
